// File: rtl/l1_dm_mem_banked.sv
// L1 data memory, multi-way and banked by byte lane, with a line-fill engine.
//
// sram_sp      : single-port byte-wide SRAM with a registered read port.
// l1_dm_mem_banked ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ_*                    core read/write request (valid/ready), byte enables
//   RESP_VAL, RESP_RDATA     registered read response, data zero when not valid
//   FILL_START/WAY/SET       start a line fill into (way, set)
//   FILL_DATA_VAL/DATA/RDY   fill beats, one word per accepted beat
//   FILL_DONE                one-cycle pulse after the last beat is written

module sram_sp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

module l1_dm_mem_banked #(
  parameter  int unsigned WIDTH          = 32,
  parameter  int unsigned WAYS           = 4,
  parameter  int unsigned SETS           = 256,
  parameter  int unsigned WORDS_PER_LINE = 4,
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned SET_W  = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VAL,
  output logic               REQ_RDY,
  input  logic               REQ_WE,
  input  logic [WAY_W-1:0]   REQ_WAY,
  input  logic [SET_W-1:0]   REQ_SET,
  input  logic [WORD_W-1:0]  REQ_WORD,
  input  logic [WIDTH/8-1:0] REQ_BE,
  input  logic [WIDTH-1:0]   REQ_WDATA,
  output logic               RESP_VAL,
  output logic [WIDTH-1:0]   RESP_RDATA,
  input  logic               FILL_START,
  input  logic [WAY_W-1:0]   FILL_WAY,
  input  logic [SET_W-1:0]   FILL_SET,
  input  logic               FILL_DATA_VAL,
  input  logic [WIDTH-1:0]   FILL_DATA,
  output logic               FILL_RDY,
  output logic               FILL_DONE
);
  localparam int unsigned BYTES  = WIDTH / 8;
  localparam int unsigned ADDR_W = SET_W + WORD_W;
  localparam int unsigned DEPTH  = SETS * WORDS_PER_LINE;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [WAY_W-1:0]    fill_way;
  logic [SET_W-1:0]    fill_set;
  logic [WORD_W-1:0]   beat_cnt;
  logic                resp_val;
  logic [WAY_W-1:0]    resp_way;

  logic                core_acc;
  logic                fill_beat;
  logic                acc_en;
  logic                acc_we;
  logic [WAY_W-1:0]    acc_way;
  logic [ADDR_W-1:0]   acc_addr;
  logic [BYTES-1:0]    acc_be;
  logic [WIDTH-1:0]    acc_data;
  logic [7:0]          lane_rdata [WAYS][BYTES];

  // Fill has priority over a core request arriving in the same IDLE cycle.
  assign REQ_RDY  = (state == IDLE) && !FILL_START;
  assign FILL_RDY = (state == FILL);
  assign RESP_VAL = resp_val;

  // Nothing reaches the arrays while RST is high, so a reset in the middle
  // of a fill cannot write one more beat.
  assign core_acc  = REQ_VAL && REQ_RDY && !RST;
  assign fill_beat = (state == FILL) && FILL_DATA_VAL && !RST;

  // Core and fill accesses are mutually exclusive (REQ_RDY=0 in FILL), so
  // one shared access port feeds every SRAM.
  always_comb begin
    acc_en   = core_acc || fill_beat;
    acc_we   = REQ_WE;
    acc_way  = REQ_WAY;
    acc_addr = {REQ_SET, REQ_WORD};
    acc_be   = REQ_BE;
    acc_data = REQ_WDATA;
    if (fill_beat) begin
      acc_we   = 1'b1;
      acc_way  = fill_way;
      acc_addr = {fill_set, beat_cnt};
      acc_be   = '1;
      acc_data = FILL_DATA;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
      logic lane_en;
      // Reads enable every lane of the way; writes only the enabled lanes.
      assign lane_en = acc_en && (acc_way == WAY_W'(w)) && (!acc_we || acc_be[b]);

      sram_sp #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
      ) u_sram (
        .clk   (CLK),
        .en    (lane_en),
        .we    (acc_we),
        .addr  (acc_addr),
        .wdata (acc_data[b*8 +: 8]),
        .rdata (lane_rdata[w][b])
      );
    end
  end

  always_comb begin
    RESP_RDATA = '0;
    if (resp_val) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        RESP_RDATA[b*8 +: 8] = lane_rdata[resp_way][b];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      fill_way  <= '0;
      fill_set  <= '0;
      FILL_DONE <= 1'b0;
      resp_val  <= 1'b0;
      resp_way  <= '0;
    end else begin
      FILL_DONE <= 1'b0;
      resp_val  <= core_acc && !REQ_WE;
      if (core_acc) resp_way <= REQ_WAY;
      case (state)
        IDLE: begin
          if (FILL_START) begin
            fill_way <= FILL_WAY;
            fill_set <= FILL_SET;
            beat_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (FILL_DATA_VAL) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state     <= IDLE;
              FILL_DONE <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_dm_mem_banked.sv
// Self-checking bench for l1_dm_mem_banked: directed scenarios followed by
// randomized reads, writes and fills, all compared against a word-level
// reference memory held in an associative array.

module tb_l1_dm_mem_banked;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 256;
  localparam int unsigned WPL    = 4;
  localparam int unsigned WAY_W  = 2;
  localparam int unsigned SET_W  = 8;
  localparam int unsigned WORD_W = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ_VAL;
  logic              REQ_RDY;
  logic              REQ_WE;
  logic [WAY_W-1:0]  REQ_WAY;
  logic [SET_W-1:0]  REQ_SET;
  logic [WORD_W-1:0] REQ_WORD;
  logic [3:0]        REQ_BE;
  logic [31:0]       REQ_WDATA;
  logic              RESP_VAL;
  logic [31:0]       RESP_RDATA;
  logic              FILL_START;
  logic [WAY_W-1:0]  FILL_WAY;
  logic [SET_W-1:0]  FILL_SET;
  logic              FILL_DATA_VAL;
  logic [31:0]       FILL_DATA;
  logic              FILL_RDY;
  logic              FILL_DONE;

  l1_dm_mem_banked #(
    .WIDTH          (WIDTH),
    .WAYS           (WAYS),
    .SETS           (SETS),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VAL       (REQ_VAL),
    .REQ_RDY       (REQ_RDY),
    .REQ_WE        (REQ_WE),
    .REQ_WAY       (REQ_WAY),
    .REQ_SET       (REQ_SET),
    .REQ_WORD      (REQ_WORD),
    .REQ_BE        (REQ_BE),
    .REQ_WDATA     (REQ_WDATA),
    .RESP_VAL      (RESP_VAL),
    .RESP_RDATA    (RESP_RDATA),
    .FILL_START    (FILL_START),
    .FILL_WAY      (FILL_WAY),
    .FILL_SET      (FILL_SET),
    .FILL_DATA_VAL (FILL_DATA_VAL),
    .FILL_DATA     (FILL_DATA),
    .FILL_RDY      (FILL_RDY),
    .FILL_DONE     (FILL_DONE)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference memory: only words whose full contents are known are present.
  logic [31:0] ref_mem [int unsigned];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned key(input int unsigned way, input int unsigned set,
                                      input int unsigned word);
    return (way * SETS + set) * WPL + word;
  endfunction

  function automatic void model_write(input int unsigned k, input logic [3:0] be,
                                      input logic [31:0] d);
    logic [31:0] mask;
    mask = 32'h0;
    for (int unsigned i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    if (be == 4'hF) ref_mem[k] = d;
    else if (ref_mem.exists(k)) ref_mem[k] = (ref_mem[k] & ~mask) | (d & mask);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input int unsigned way, input int unsigned set,
                          input int unsigned word, input logic [3:0] be,
                          input logic [31:0] d);
    REQ_VAL = 1'b1; REQ_WE = 1'b1; REQ_BE = be; REQ_WDATA = d;
    REQ_WAY = WAY_W'(way); REQ_SET = SET_W'(set); REQ_WORD = WORD_W'(word);
    #1;
    check("wr_req_rdy", REQ_RDY, 1);
    tick();
    REQ_VAL = 1'b0; REQ_WE = 1'b0;
    model_write(key(way, set, word), be, d);
    check("wr_no_resp_val", RESP_VAL, 0);
    check("wr_no_resp_data", RESP_RDATA, 0);
  endtask

  task automatic do_read(input int unsigned way, input int unsigned set,
                         input int unsigned word);
    int unsigned k;
    k = key(way, set, word);
    REQ_VAL = 1'b1; REQ_WE = 1'b0; REQ_BE = 4'h0;
    REQ_WAY = WAY_W'(way); REQ_SET = SET_W'(set); REQ_WORD = WORD_W'(word);
    #1;
    check("rd_req_rdy", REQ_RDY, 1);
    tick();
    REQ_VAL = 1'b0;
    check("rd_resp_val", RESP_VAL, 1);
    if (ref_mem.exists(k)) check("rd_resp_data", RESP_RDATA, ref_mem[k]);
  endtask

  task automatic fill_start(input int unsigned way, input int unsigned set);
    FILL_START = 1'b1; FILL_WAY = WAY_W'(way); FILL_SET = SET_W'(set);
    #1;
    check("fill_start_req_rdy", REQ_RDY, 0);
    tick();
    FILL_START = 1'b0;
  endtask

  // Sends beats first..first+n-1; gaps[i] inserts one idle cycle before beat i.
  task automatic fill_beats(input int unsigned way, input int unsigned set,
                            input int unsigned first, input int unsigned n,
                            input logic [31:0] d [4], input logic [3:0] gaps);
    for (int unsigned i = first; i < first + n; i++) begin
      if (gaps[i]) begin
        FILL_DATA_VAL = 1'b0;
        FILL_DATA = $urandom;
        #1;
        check("fill_gap_fill_rdy", FILL_RDY, 1);
        check("fill_gap_req_rdy", REQ_RDY, 0);
        check("fill_gap_done", FILL_DONE, 0);
        tick();
      end
      FILL_DATA_VAL = 1'b1;
      FILL_DATA = d[i];
      #1;
      check("fill_beat_fill_rdy", FILL_RDY, 1);
      check("fill_beat_req_rdy", REQ_RDY, 0);
      check("fill_beat_done", FILL_DONE, 0);
      check("fill_beat_resp_val", RESP_VAL, 0);
      tick();
      ref_mem[key(way, set, i)] = d[i];
    end
    FILL_DATA_VAL = 1'b0;
  endtask

  task automatic full_fill(input int unsigned way, input int unsigned set,
                           input logic [31:0] d [4], input logic [3:0] gaps);
    fill_start(way, set);
    fill_beats(way, set, 0, WPL, d, gaps);
    check("fill_done_pulse", FILL_DONE, 1);
    check("fill_end_fill_rdy", FILL_RDY, 0);
    tick();
    check("fill_done_clear", FILL_DONE, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] beats [4];
    logic [31:0] old [4];
    int unsigned way, set, word, op;

    RST = 1'b1; REQ_VAL = 1'b0; REQ_WE = 1'b0; REQ_WAY = '0; REQ_SET = '0;
    REQ_WORD = '0; REQ_BE = '0; REQ_WDATA = '0; FILL_START = 1'b0;
    FILL_WAY = '0; FILL_SET = '0; FILL_DATA_VAL = 1'b0; FILL_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("rst_resp_val", RESP_VAL, 0);
    check("rst_resp_data", RESP_RDATA, 0);
    check("rst_fill_done", FILL_DONE, 0);
    check("rst_fill_rdy", FILL_RDY, 0);
    check("rst_req_rdy", REQ_RDY, 1);

    // Basic write/read and way isolation.
    do_write(1, 5, 3, 4'hF, 32'h0123_4567);
    do_write(2, 5, 3, 4'hF, 32'hDEAD_BEEF);
    do_read(2, 5, 3);
    check("basic_data", RESP_RDATA, 32'hDEAD_BEEF);
    do_read(1, 5, 3);
    check("other_way_untouched", RESP_RDATA, 32'h0123_4567);
    tick();
    check("idle_resp_val", RESP_VAL, 0);
    check("idle_resp_data", RESP_RDATA, 0);

    // Byte enables.
    do_write(0, 6, 1, 4'hF, 32'h1122_3344);
    do_write(0, 6, 1, 4'h5, 32'hAABB_CCDD);
    do_read(0, 6, 1);
    check("be_merge", RESP_RDATA, 32'h11BB_33DD);
    do_write(0, 6, 1, 4'h0, 32'hFFFF_FFFF);
    do_read(0, 6, 1);
    check("be_zero", RESP_RDATA, 32'h11BB_33DD);

    // Line fill with an idle cycle between beats 1 and 2.
    beats = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    full_fill(3, 8'h7F, beats, 4'b0100);
    for (int unsigned i = 0; i < WPL; i++) begin
      do_read(3, 8'h7F, i);
      check("fill_word", RESP_RDATA, 32'hA0 + i);
    end

    // Fill start wins over a read in the same cycle; read waits until IDLE.
    REQ_VAL = 1'b1; REQ_WE = 1'b0; REQ_WAY = 2'd3; REQ_SET = 8'h7F; REQ_WORD = 2'd2;
    FILL_START = 1'b1; FILL_WAY = 2'd0; FILL_SET = 8'h20;
    #1;
    check("prio_req_rdy", REQ_RDY, 0);
    tick();
    FILL_START = 1'b0;
    check("prio_no_resp", RESP_VAL, 0);
    for (int unsigned i = 0; i < 4; i++) beats[i] = $urandom;
    fill_beats(0, 8'h20, 0, WPL, beats, 4'b0000);
    #1;
    check("prio_done", FILL_DONE, 1);
    check("prio_req_rdy_back", REQ_RDY, 1);
    tick();
    REQ_VAL = 1'b0;
    check("prio_resp_val", RESP_VAL, 1);
    check("prio_resp_data", RESP_RDATA, 32'hA2);

    // Reset after two of four fill beats.
    for (int unsigned i = 0; i < 4; i++) begin
      old[i] = $urandom;
      do_write(0, 9, i, 4'hF, old[i]);
    end
    for (int unsigned i = 0; i < 4; i++) beats[i] = $urandom;
    fill_start(0, 9);
    fill_beats(0, 9, 0, 2, beats, 4'b0000);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("mid_rst_req_rdy", REQ_RDY, 1);
    check("mid_rst_fill_rdy", FILL_RDY, 0);
    check("mid_rst_done", FILL_DONE, 0);
    FILL_DATA_VAL = 1'b1; FILL_DATA = 32'hBAD0_BAD0;
    repeat (2) begin
      tick();
      check("mid_rst_no_done", FILL_DONE, 0);
      check("idle_fill_rdy", FILL_RDY, 0);
    end
    FILL_DATA_VAL = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      do_read(0, 9, i);
      check("mid_rst_word", RESP_RDATA, (i < 2) ? beats[i] : old[i]);
    end
    tick();

    // Eight back-to-back reads of distinct addresses.
    for (int unsigned i = 0; i < 8; i++) do_write(i % 4, 8'h40 + i, i % 4, 4'hF, $urandom);
    check("b2b_pre_val", RESP_VAL, 0);
    for (int unsigned i = 0; i < 8; i++) do_read(i % 4, 8'h40 + i, i % 4);
    check("b2b_post_val", RESP_VAL, 1);
    tick();
    check("b2b_end_val", RESP_VAL, 0);
    check("b2b_end_data", RESP_RDATA, 0);

    // Reset coincident with an accepted read.
    REQ_VAL = 1'b1; REQ_WE = 1'b0; REQ_WAY = 2'd2; REQ_SET = 8'd5; REQ_WORD = 2'd3;
    RST = 1'b1;
    tick();
    RST = 1'b0; REQ_VAL = 1'b0;
    check("rst_read_val", RESP_VAL, 0);
    check("rst_read_data", RESP_RDATA, 0);

    // Randomized traffic over a small address pool.
    for (int unsigned n = 0; n < 200; n++) begin
      op   = $urandom_range(0, 9);
      way  = $urandom_range(0, WAYS - 1);
      set  = $urandom_range(0, 7);
      word = $urandom_range(0, WPL - 1);
      if (op == 0) begin
        for (int unsigned i = 0; i < 4; i++) beats[i] = $urandom;
        full_fill(way, set, beats, 4'($urandom_range(0, 15)));
      end else if (op < 5) begin
        do_write(way, set, word, 4'($urandom_range(0, 15)), $urandom);
      end else begin
        do_read(way, set, word);
        if ($urandom_range(0, 1) == 1) begin
          tick();
          check("rnd_idle_data", RESP_RDATA, 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
